// File: rtl/writeback_queue.sv
// Writeback buffer in front of the dual-write-port GPR/HI/LO register file.
// In-order GPR FIFO (2 in / 2 out per cycle), a HI/LO holding register and a pending-write lookup.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in_ready,
  input  logic              hilo_valid,
  input  logic              hilo_hi_we,
  input  logic              hilo_lo_we,
  input  logic [DATA_W-1:0] hilo_hi_in,
  input  logic [DATA_W-1:0] hilo_lo_in,
  output logic              hilo_ready,
  output logic [ADDR_W-1:0] write_addr0,
  output logic              write_addr0_valid,
  output logic [DATA_W-1:0] write_data0,
  output logic [ADDR_W-1:0] write_addr1,
  output logic              write_addr1_valid,
  output logic [DATA_W-1:0] write_data1,
  output logic [DATA_W-1:0] write_hilo_hi_data,
  output logic              write_hilo_hi_data_valid,
  output logic [DATA_W-1:0] write_hilo_lo_data,
  output logic              write_hilo_lo_data_valid,
  input  logic [ADDR_W-1:0] q_addr0,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic              q_hit0,
  output logic              q_hit1,
  output logic [DATA_W-1:0] q_data0,
  output logic [DATA_W-1:0] q_data1,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, wr_ptr1, rd_ptr1;
  logic [CNT_W-1:0]  count, n_drain, n_enq;
  logic              store0, store1;

  logic              held, hi_we_q, lo_we_q, hilo_load;
  logic [DATA_W-1:0] hi_q, lo_q;

  // in_ready depends only on registered count: no credit for the same-cycle drain.
  assign in_ready = (CNT_W'(DEPTH) - count) >= CNT_W'(2);

  // Writes to r0 are accepted but never occupy an entry.
  assign store0  = in0_valid & in_ready & (in0_addr != '0);
  assign store1  = in1_valid & in_ready & (in1_addr != '0);
  assign n_enq   = CNT_W'(store0) + CNT_W'(store1);
  assign n_drain = (count >= CNT_W'(2)) ? CNT_W'(2) : count;
  assign wr_ptr1 = wr_ptr + PTR_W'(store0);
  assign rd_ptr1 = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count  <= count - n_drain + n_enq;
      rd_ptr <= rd_ptr + PTR_W'(n_drain);
      wr_ptr <= wr_ptr + PTR_W'(n_enq);
    end
  end

  // NOTE: storage is deliberately not reset; every reader is qualified by count or held.
  always_ff @(posedge clk) begin
    if (store0) mem[wr_ptr]  <= '{addr: in0_addr, data: in0_data};
    if (store1) mem[wr_ptr1] <= '{addr: in1_addr, data: in1_data};
    if (hilo_load) begin
      hi_q <= hilo_hi_in;
      lo_q <= hilo_lo_in;
    end
  end

  assign write_addr0_valid = (count != '0);
  assign write_addr1_valid = (count >= CNT_W'(2));
  assign write_addr0       = write_addr0_valid ? mem[rd_ptr].addr  : '0;
  assign write_data0       = write_addr0_valid ? mem[rd_ptr].data  : '0;
  assign write_addr1       = write_addr1_valid ? mem[rd_ptr1].addr : '0;
  assign write_data1       = write_addr1_valid ? mem[rd_ptr1].data : '0;

  // Walk from oldest to youngest so the last match left standing is the youngest.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (addr != '0) && (mem[idx].addr == addr))
        res = {1'b1, mem[idx].data};
    end
    return res;
  endfunction

  assign {q_hit0, q_data0} = lookup(q_addr0);
  assign {q_hit1, q_data1} = lookup(q_addr1);

  // HI/LO holding register: loads for one cycle, then clears unconditionally.
  assign hilo_ready = !held;
  assign hilo_load  = hilo_valid & !held & (hilo_hi_we | hilo_lo_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      held    <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
    end else if (hilo_load) begin
      held    <= 1'b1;
      hi_we_q <= hilo_hi_we;
      lo_we_q <= hilo_lo_we;
    end else begin
      held    <= 1'b0;
      hi_we_q <= 1'b0;
      lo_we_q <= 1'b0;
    end
  end

  assign write_hilo_hi_data_valid = held & hi_we_q;
  assign write_hilo_lo_data_valid = held & lo_we_q;
  assign write_hilo_hi_data       = write_hilo_hi_data_valid ? hi_q : '0;
  assign write_hilo_lo_data       = write_hilo_lo_data_valid ? lo_q : '0;

  assign empty = (count == '0) && !held;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue with a small register-file model on its write ports.
module tb_writeback_queue;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              in0_valid, in1_valid, in_ready;
  logic [ADDR_W-1:0] in0_addr, in1_addr;
  logic [DATA_W-1:0] in0_data, in1_data;
  logic              hilo_valid, hilo_hi_we, hilo_lo_we, hilo_ready;
  logic [DATA_W-1:0] hilo_hi_in, hilo_lo_in;
  logic [ADDR_W-1:0] write_addr0, write_addr1;
  logic              write_addr0_valid, write_addr1_valid;
  logic [DATA_W-1:0] write_data0, write_data1;
  logic [DATA_W-1:0] write_hilo_hi_data, write_hilo_lo_data;
  logic              write_hilo_hi_data_valid, write_hilo_lo_data_valid;
  logic [ADDR_W-1:0] q_addr0, q_addr1;
  logic              q_hit0, q_hit1;
  logic [DATA_W-1:0] q_data0, q_data1;
  logic              empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] rf [32];

  writeback_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
    .in_ready(in_ready),
    .hilo_valid(hilo_valid), .hilo_hi_we(hilo_hi_we), .hilo_lo_we(hilo_lo_we),
    .hilo_hi_in(hilo_hi_in), .hilo_lo_in(hilo_lo_in), .hilo_ready(hilo_ready),
    .write_addr0(write_addr0), .write_addr0_valid(write_addr0_valid), .write_data0(write_data0),
    .write_addr1(write_addr1), .write_addr1_valid(write_addr1_valid), .write_data1(write_data1),
    .write_hilo_hi_data(write_hilo_hi_data), .write_hilo_hi_data_valid(write_hilo_hi_data_valid),
    .write_hilo_lo_data(write_hilo_lo_data), .write_hilo_lo_data_valid(write_hilo_lo_data_valid),
    .q_addr0(q_addr0), .q_addr1(q_addr1), .q_hit0(q_hit0), .q_hit1(q_hit1),
    .q_data0(q_data0), .q_data1(q_data1), .empty(empty)
  );

  always #5 clk = ~clk;

  // Register file: port 1 is applied after port 0, so the younger write wins.
  always @(posedge clk) begin
    if (write_addr0_valid) rf[write_addr0] <= write_data0;
    if (write_addr1_valid) rf[write_addr1] <= write_data1;
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
    in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
    hilo_valid = 1'b0; hilo_hi_we = 1'b0; hilo_lo_we = 1'b0;
    hilo_hi_in = '0; hilo_lo_in = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},   in_ready, 1);
    check({tag, "_hilo_ready"}, hilo_ready, 1);
    check({tag, "_empty"},      empty, 1);
    check({tag, "_v0"},         write_addr0_valid, 0);
    check({tag, "_v1"},         write_addr1_valid, 0);
    check({tag, "_a0"},         write_addr0, 0);
    check({tag, "_d1"},         write_data1, 0);
    check({tag, "_hi_v"},       write_hilo_hi_data_valid, 0);
    check({tag, "_hi_d"},       write_hilo_hi_data, 0);
    check({tag, "_lo_v"},       write_hilo_lo_data_valid, 0);
    check({tag, "_hit0"},       q_hit0, 0);
    check({tag, "_qd0"},        q_data0, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    idle_inputs();
    q_addr0 = 5'd3; q_addr1 = 5'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("rst");

    // 1) same-address pair: both presented, younger lands last
    in0_valid = 1; in0_addr = 3; in0_data = 32'h11;
    in1_valid = 1; in1_addr = 3; in1_data = 32'h22;
    tick();
    idle_inputs();
    check("t1_v0", write_addr0_valid, 1);
    check("t1_v1", write_addr1_valid, 1);
    check("t1_a0", write_addr0, 3);
    check("t1_a1", write_addr1, 3);
    check("t1_d0", write_data0, 32'h11);
    check("t1_d1", write_data1, 32'h22);
    check("t1_hit", q_hit0, 1);
    check("t1_qd", q_data0, 32'h22);
    tick();
    check("t1_rf3", rf[3], 32'h22);
    check("t1_empty", empty, 1);

    // 2) two pairs per cycle for three cycles
    for (int k = 0; k < 3; k++) begin
      in0_valid = 1; in0_addr = ADDR_W'(1 + 2*k); in0_data = 32'hA0 + k;
      in1_valid = 1; in1_addr = ADDR_W'(2 + 2*k); in1_data = 32'hB0 + k;
      tick();
      check("t2_ready", in_ready, 1);
      check("t2_a0", write_addr0, ADDR_W'(1 + 2*k));
      check("t2_d0", write_data0, 32'hA0 + k);
      check("t2_a1", write_addr1, ADDR_W'(2 + 2*k));
      check("t2_d1", write_data1, 32'hB0 + k);
    end
    idle_inputs();
    tick();
    check("t2_rf1", rf[1], 32'hA0);
    check("t2_rf4", rf[4], 32'hB1);
    check("t2_rf6", rf[6], 32'hB2);
    check("t2_empty", empty, 1);

    // 3) slot1-only bursts walk the pointers past the wrap point
    for (int k = 0; k < 6; k++) begin
      in1_valid = 1; in1_addr = ADDR_W'(10 + k); in1_data = 32'hC0 + k;
      tick();
      check("t3_ready", in_ready, 1);
      check("t3_v0", write_addr0_valid, 1);
      check("t3_a0", write_addr0, ADDR_W'(10 + k));
      check("t3_d0", write_data0, 32'hC0 + k);
      check("t3_v1", write_addr1_valid, 0);
    end
    idle_inputs();
    tick();
    check("t3_rf15", rf[15], 32'hC5);

    // 4) r0 write is dropped, r5 takes the head slot
    in0_valid = 1; in0_addr = 0; in0_data = 32'hFF;
    in1_valid = 1; in1_addr = 5; in1_data = 32'h55;
    q_addr0 = 0; q_addr1 = 5;
    tick();
    idle_inputs();
    check("t4_v0", write_addr0_valid, 1);
    check("t4_a0", write_addr0, 5);
    check("t4_d0", write_data0, 32'h55);
    check("t4_v1", write_addr1_valid, 0);
    check("t4_hit0", q_hit0, 0);
    check("t4_hit1", q_hit1, 1);
    check("t4_qd1", q_data1, 32'h55);
    tick();
    check("t4_rf0", rf[0], 0);

    // 5) youngest-match lookup; same-cycle inputs invisible
    q_addr0 = 7; q_addr1 = 9;
    in0_valid = 1; in0_addr = 7; in0_data = 32'hA;
    in1_valid = 1; in1_addr = 7; in1_data = 32'hB;
    #1;
    check("t5_pre_hit", q_hit0, 0);
    tick();
    idle_inputs();
    check("t5_hit", q_hit0, 1);
    check("t5_qd", q_data0, 32'hB);
    check("t5_miss9", q_hit1, 0);
    tick();
    check("t5_gone", q_hit0, 0);
    check("t5_gone_d", q_data0, 0);

    // 6a) HI/LO load, one-cycle write, then clear
    hilo_valid = 1; hilo_hi_we = 1; hilo_lo_we = 1;
    hilo_hi_in = 32'h1234; hilo_lo_in = 32'h5678;
    tick();
    idle_inputs();
    check("t6_hi_v", write_hilo_hi_data_valid, 1);
    check("t6_hi_d", write_hilo_hi_data, 32'h1234);
    check("t6_lo_v", write_hilo_lo_data_valid, 1);
    check("t6_lo_d", write_hilo_lo_data, 32'h5678);
    check("t6_ready", hilo_ready, 0);
    check("t6_empty", empty, 0);
    tick();
    check("t6_clr_v", write_hilo_hi_data_valid, 0);
    check("t6_clr_rdy", hilo_ready, 1);
    check("t6_clr_empty", empty, 1);

    // 6b) reset lands while HI held and a GPR pair is draining
    hilo_valid = 1; hilo_hi_we = 1; hilo_lo_we = 0; hilo_hi_in = 32'h1234;
    in0_valid = 1; in0_addr = 20; in0_data = 32'hDD;
    in1_valid = 1; in1_addr = 21; in1_data = 32'hEE;
    q_addr0 = 20;
    tick();
    idle_inputs();
    check("t6b_hi_v", write_hilo_hi_data_valid, 1);
    check("t6b_lo_v", write_hilo_lo_data_valid, 0);
    check("t6b_v1", write_addr1_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
